// File: rtl/mem_access_stage_pkg.sv
// Shared CPU word/register types and the MEM-stage control enums.
package cpu_types_pkg;
  localparam int WORD_W    = 32;
  localparam int REGBITS_W = 5;
  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REGBITS_W-1:0] regbits_t;
endpackage

package control_unit_types_pkg;
  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_NPC = 2'd2
  } memtoreg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memst_t;
endpackage

// File: rtl/mem_access_stage_mm_wb_mux.sv
// Write-back source select shared by the MEM/WB latch and the forwarding path.
module mm_wb_mux
  import control_unit_types_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  memtoreg_t         memtoreg_i,
  input  logic              is_load_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] load_i,
  input  logic [DATA_W-1:0] npc_i,
  output logic [DATA_W-1:0] wdat_o
);

  always_comb begin
    wdat_o = alu_i;
    unique case (memtoreg_i)
      MTR_MEM: if (is_load_i) wdat_o = load_i;  // MEM select without a read falls back to ALU
      MTR_NPC: wdat_o = npc_i;
      default: wdat_o = alu_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: dcache request/stall FSM, MEM/WB latch and MEM-stage forwarding.
// Optional load-linked/store-conditional support is built when LLSC_EN is defined.
module mem_access_stage
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;
#(
  parameter int DATA_W = $bits(word_t),
  parameter int REG_W  = $bits(regbits_t)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mm_valid,
  input  logic              mm_dREN,
  input  logic              mm_dWEN,
  input  logic              mm_RegWEN,
  input  logic [1:0]        mm_MemtoReg,
  input  logic [REG_W-1:0]  mm_rd,
  input  logic [DATA_W-1:0] mm_ALUOut,
  input  logic [DATA_W-1:0] mm_store,
  input  logic [DATA_W-1:0] mm_npc,
  input  logic              mm_halt,
  input  logic              mm_ll,
  input  logic              mm_sc,
  input  logic              wb_en,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mm_stall,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_valid,
  output logic              wb_RegWEN,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_wdat,
  output logic              wb_halt
);

  memst_t            state_q, state_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              halted_q, halted_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwen_q, wb_regwen_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_wdat_q, wb_wdat_d;
  logic [DATA_W-1:0] wdat_sel, fwd_sel;
  logic              mem_op, is_load, sc_fail, done_now, req_en, fwd_ok;

  assign mem_op  = mm_valid & (mm_dREN | mm_dWEN) & ~halted_q;
  assign is_load = mm_dREN & ~mm_dWEN & ~halted_q;

`ifdef LLSC_EN
  logic              link_valid_q, link_valid_d;
  logic [DATA_W-1:0] link_addr_q, link_addr_d;
  logic              is_sc, sc_ok;

  assign is_sc   = mm_sc & mm_dWEN;
  assign sc_ok   = link_valid_q && (link_addr_q == mm_ALUOut);
  assign sc_fail = is_sc & ~sc_ok;
  // The SC result is produced here, not by the ALU, so it is never forwarded.
  assign fwd_ok  = ~is_sc;

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (wb_en && !mm_stall && mm_valid && !halted_q) begin
      if (is_sc) begin
        link_valid_d = 1'b0;
      end else if (mm_dREN && mm_ll) begin
        link_valid_d = 1'b1;
        link_addr_d  = mm_ALUOut;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`else
  logic unused_llsc;
  assign unused_llsc = mm_ll ^ mm_sc;
  assign sc_fail     = 1'b0;
  assign fwd_ok      = 1'b1;
`endif

  // A failed SC never touches the bus and completes like an immediate hit.
  assign done_now = dhit | sc_fail;

  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    req_en   = 1'b0;
    mm_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_en   = 1'b1;
          mm_stall = ~done_now;
          if (dhit) load_d = dmemload;
          state_d  = done_now ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        req_en   = 1'b1;
        mm_stall = 1'b1;
        if (dhit) begin
          load_d  = dmemload;
          state_d = DONE;
        end
      end
      DONE: begin
        if (wb_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmemREN   = req_en & mem_op & ~mm_dWEN;
  assign dmemWEN   = req_en & mem_op & mm_dWEN & ~sc_fail;
  assign dmemaddr  = (dmemREN | dmemWEN) ? mm_ALUOut : '0;
  assign dmemstore = dmemWEN ? mm_store : '0;

  mm_wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .memtoreg_i (memtoreg_t'(mm_MemtoReg)),
    .is_load_i  (is_load),
    .alu_i      (mm_ALUOut),
    .load_i     (load_d),
    .npc_i      (mm_npc),
    .wdat_o     (wdat_sel)
  );

  mm_wb_mux #(.DATA_W(DATA_W)) u_fwd_mux (
    .memtoreg_i (memtoreg_t'(mm_MemtoReg)),
    .is_load_i  (1'b0),
    .alu_i      (mm_ALUOut),
    .load_i     ('0),
    .npc_i      (mm_npc),
    .wdat_o     (fwd_sel)
  );

  assign fwd_valid = mm_valid & mm_RegWEN & (mm_rd != '0) & ~mm_dREN & fwd_ok;
  assign fwd_rd    = mm_rd;
  assign fwd_data  = fwd_sel;

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_regwen_d = wb_regwen_q;
    wb_rd_d     = wb_rd_q;
    wb_wdat_d   = wb_wdat_q;
    halted_d    = halted_q;
    if (wb_en) begin
      if (mm_stall) begin
        wb_valid_d  = 1'b0;
        wb_regwen_d = 1'b0;
      end else begin
        wb_valid_d  = mm_valid;
        wb_regwen_d = mm_valid & mm_RegWEN & ~halted_q;
        wb_rd_d     = mm_rd;
        wb_wdat_d   = wdat_sel;
`ifdef LLSC_EN
        if (is_sc) wb_wdat_d = {{(DATA_W-1){1'b0}}, sc_ok};
`endif
        if (mm_valid && mm_halt) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      load_q      <= '0;
      halted_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_regwen_q <= 1'b0;
      wb_rd_q     <= '0;
      wb_wdat_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      halted_q    <= halted_d;
      wb_valid_q  <= wb_valid_d;
      wb_regwen_q <= wb_regwen_d;
      wb_rd_q     <= wb_rd_d;
      wb_wdat_q   <= wb_wdat_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_RegWEN = wb_regwen_q;
  assign wb_rd     = wb_rd_q;
  assign wb_wdat   = wb_wdat_q;
  assign wb_halt   = halted_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (LLSC cases only when LLSC_EN is defined).
module tb_mem_access_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        mm_valid, mm_dREN, mm_dWEN, mm_RegWEN, mm_halt, mm_ll, mm_sc;
  logic [1:0]  mm_MemtoReg;
  logic [4:0]  mm_rd;
  logic [31:0] mm_ALUOut, mm_store, mm_npc, dmemload;
  logic        wb_en, dhit;
  logic        dmemREN, dmemWEN, mm_stall, fwd_valid, wb_valid, wb_RegWEN, wb_halt;
  logic [31:0] dmemaddr, dmemstore, fwd_data, wb_wdat;
  logic [4:0]  fwd_rd, wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_access_stage dut (
    .CLK(CLK), .nRST(nRST),
    .mm_valid(mm_valid), .mm_dREN(mm_dREN), .mm_dWEN(mm_dWEN), .mm_RegWEN(mm_RegWEN),
    .mm_MemtoReg(mm_MemtoReg), .mm_rd(mm_rd), .mm_ALUOut(mm_ALUOut), .mm_store(mm_store),
    .mm_npc(mm_npc), .mm_halt(mm_halt), .mm_ll(mm_ll), .mm_sc(mm_sc),
    .wb_en(wb_en), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mm_stall(mm_stall), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_RegWEN(wb_RegWEN), .wb_rd(wb_rd), .wb_wdat(wb_wdat),
    .wb_halt(wb_halt)
  );

  task automatic nop();
    mm_valid = 0; mm_dREN = 0; mm_dWEN = 0; mm_RegWEN = 0; mm_halt = 0;
    mm_ll = 0; mm_sc = 0; mm_MemtoReg = 2'd0; mm_rd = 0;
    mm_ALUOut = 0; mm_store = 0; mm_npc = 0; dhit = 0; dmemload = 0; wb_en = 1;
  endtask

  task automatic nop_cycle();
    @(negedge CLK); nop(); #1;
  endtask

  task automatic test_reset();
    nRST = 0; nop();
    @(negedge CLK); #1;
    $display("reset: asserted");
    checks++; if ({dmemREN, dmemWEN, mm_stall, fwd_valid} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b required 0000", {dmemREN, dmemWEN, mm_stall, fwd_valid}); end
    checks++; if ({dmemaddr, dmemstore} !== 64'd0) begin errors++; $display("FAIL reset_bus: got %h required 0", {dmemaddr, dmemstore}); end
    checks++; if ({wb_valid, wb_RegWEN, wb_halt, wb_rd, wb_wdat} !== 40'd0) begin errors++; $display("FAIL reset_wb: got %h required 0", {wb_valid, wb_RegWEN, wb_halt, wb_rd, wb_wdat}); end
    @(negedge CLK); nRST = 1;
  endtask

  task automatic test_alu_fwd();
    @(negedge CLK); nop();
    mm_valid = 1; mm_RegWEN = 1; mm_rd = 5; mm_ALUOut = 32'h55; mm_MemtoReg = 2'd0; #1;
    $display("add rd=5 result=0x55");
    checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL add_fwd_valid: got %b required 1", fwd_valid); end
    checks++; if (fwd_data !== 32'h55 || fwd_rd !== 5'd5) begin errors++; $display("FAIL add_fwd_data: got %h/%0d required 55/5", fwd_data, fwd_rd); end
    checks++; if (mm_stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b required 0", mm_stall); end
    @(negedge CLK); nop(); mm_valid = 1; mm_RegWEN = 1; mm_rd = 0; mm_ALUOut = 32'h66; #1;
    checks++; if (wb_wdat !== 32'h55 || wb_rd !== 5'd5 || wb_RegWEN !== 1'b1 || wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb: got %h/%0d/%b/%b required 55/5/1/1", wb_wdat, wb_rd, wb_RegWEN, wb_valid); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL add_r0_fwd: got %b required 0", fwd_valid); end
    nop_cycle();
  endtask

  task automatic test_lw();
    int stalls = 0;
    int reqs = 0;
    @(negedge CLK); nop(); mm_valid = 1; mm_RegWEN = 1; mm_rd = 3; mm_ALUOut = 32'h9;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); nop();
      mm_valid = 1; mm_dREN = 1; mm_RegWEN = 1; mm_MemtoReg = 2'd1; mm_rd = 8; mm_ALUOut = 32'h40;
      dhit = (i == 2); dmemload = (i == 2) ? 32'hDEADBEEF : 32'h0; #1;
      stalls += int'(mm_stall); reqs += int'(dmemREN);
      if (i == 0) begin
        checks++; if (dmemaddr !== 32'h40 || dmemWEN !== 1'b0) begin errors++; $display("FAIL lw_addr: got %h/%b required 40/0", dmemaddr, dmemWEN); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL lw_fwd: got %b required 0", fwd_valid); end
      end
      if (i == 1) begin
        checks++; if (wb_valid !== 1'b0 || wb_RegWEN !== 1'b0) begin errors++; $display("FAIL lw_bubble: got %b/%b required 0/0", wb_valid, wb_RegWEN); end
      end
      if (i == 3) begin
        checks++; if (mm_stall !== 1'b0 || dmemREN !== 1'b0) begin errors++; $display("FAIL lw_done: got stall %b ren %b required 0/0", mm_stall, dmemREN); end
      end
    end
    $display("lw addr=0x40 stalls=%0d reqs=%0d", stalls, reqs);
    checks++; if (stalls != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d required 3", stalls); end
    checks++; if (reqs != 3) begin errors++; $display("FAIL lw_req_cycles: got %0d required 3", reqs); end
    nop_cycle();
    checks++; if (wb_wdat !== 32'hDEADBEEF || wb_rd !== 5'd8 || wb_valid !== 1'b1 || wb_RegWEN !== 1'b1) begin errors++; $display("FAIL lw_wb: got %h/%0d/%b/%b required deadbeef/8/1/1", wb_wdat, wb_rd, wb_valid, wb_RegWEN); end
  endtask

  task automatic test_sw();
    @(negedge CLK); nop();
    mm_valid = 1; mm_dWEN = 1; mm_ALUOut = 32'h80; mm_store = 32'h1234; dhit = 1; #1;
    $display("sw addr=0x80 data=0x1234 hit same cycle");
    checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || mm_stall !== 1'b0) begin errors++; $display("FAIL sw_req: got wen %b ren %b stall %b required 1/0/0", dmemWEN, dmemREN, mm_stall); end
    checks++; if (dmemaddr !== 32'h80 || dmemstore !== 32'h1234) begin errors++; $display("FAIL sw_bus: got %h/%h required 80/1234", dmemaddr, dmemstore); end
    nop_cycle();
    checks++; if (dmemWEN !== 1'b0 || wb_RegWEN !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL sw_after: got wen %b regwen %b valid %b required 0/0/1", dmemWEN, wb_RegWEN, wb_valid); end
    nop_cycle();
    @(negedge CLK); nop();
    mm_valid = 1; mm_dREN = 1; mm_dWEN = 1; mm_ALUOut = 32'h84; dhit = 1; #1;
    $display("ren+wen both latched addr=0x84");
    checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin errors++; $display("FAIL both_write_wins: got wen %b ren %b required 1/0", dmemWEN, dmemREN); end
    nop_cycle(); nop_cycle();
  endtask

  task automatic test_jal_illegal();
    @(negedge CLK); nop();
    mm_valid = 1; mm_RegWEN = 1; mm_MemtoReg = 2'd2; mm_rd = 31; mm_npc = 32'h104; mm_ALUOut = 32'h999; #1;
    $display("jal npc=0x104 rd=31");
    checks++; if (fwd_data !== 32'h104) begin errors++; $display("FAIL jal_fwd: got %h required 104", fwd_data); end
    @(negedge CLK); nop();
    mm_valid = 1; mm_RegWEN = 1; mm_MemtoReg = 2'd1; mm_rd = 4; mm_ALUOut = 32'h77; #1;
    $display("memtoreg=MEM without read alu=0x77");
    checks++; if (wb_wdat !== 32'h104 || wb_rd !== 5'd31) begin errors++; $display("FAIL jal_wb: got %h/%0d required 104/31", wb_wdat, wb_rd); end
    checks++; if (fwd_data !== 32'h77 || fwd_valid !== 1'b1) begin errors++; $display("FAIL illegal_fwd: got %h/%b required 77/1", fwd_data, fwd_valid); end
    nop_cycle();
    checks++; if (wb_wdat !== 32'h77) begin errors++; $display("FAIL illegal_wb: got %h required 77", wb_wdat); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); nop();
      mm_valid = 1; mm_dREN = 1; mm_RegWEN = 1; mm_MemtoReg = 2'd1; mm_rd = 9; mm_ALUOut = 32'h44;
      wb_en = (i == 0 || i == 3); dhit = (i == 1); dmemload = (i == 1) ? 32'hCAFEF00D : 32'h0; #1;
      if (i == 1) begin
        checks++; if (mm_stall !== 1'b1 || dmemREN !== 1'b1) begin errors++; $display("FAIL frz_access: got stall %b ren %b required 1/1", mm_stall, dmemREN); end
      end
      if (i >= 2) begin
        checks++; if (mm_stall !== 1'b0 || dmemREN !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL frz_done%0d: got stall %b ren %b valid %b required 0/0/0", i, mm_stall, dmemREN, wb_valid); end
      end
    end
    $display("lw addr=0x44 with wb_en freeze during hit");
    nop_cycle();
    checks++; if (wb_wdat !== 32'hCAFEF00D || wb_rd !== 5'd9 || wb_valid !== 1'b1) begin errors++; $display("FAIL frz_wb: got %h/%0d/%b required cafef00d/9/1", wb_wdat, wb_rd, wb_valid); end
  endtask

`ifdef LLSC_EN
  task automatic test_llsc();
    @(negedge CLK); nop();
    mm_valid = 1; mm_dREN = 1; mm_ll = 1; mm_RegWEN = 1; mm_MemtoReg = 2'd1; mm_rd = 2;
    mm_ALUOut = 32'h200; dhit = 1; dmemload = 32'h11;
    $display("ll addr=0x200");
    nop_cycle(); nop_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); nop();
      mm_valid = 1; mm_dWEN = 1; mm_sc = 1; mm_RegWEN = 1; mm_rd = 2; mm_ALUOut = 32'h200;
      mm_store = 32'h9; dhit = (i == 1); #1;
      if (i == 0) begin
        checks++; if (dmemWEN !== 1'b1 || mm_stall !== 1'b1) begin errors++; $display("FAIL sc1_req: got wen %b stall %b required 1/1", dmemWEN, mm_stall); end
      end
    end
    $display("sc addr=0x200 (linked)");
    nop_cycle();
    checks++; if (wb_wdat !== 32'h1) begin errors++; $display("FAIL sc1_wb: got %h required 1", wb_wdat); end
    nop_cycle();
    @(negedge CLK); nop();
    mm_valid = 1; mm_dWEN = 1; mm_sc = 1; mm_RegWEN = 1; mm_rd = 2; mm_ALUOut = 32'h200; #1;
    $display("sc addr=0x200 (link cleared)");
    checks++; if (dmemWEN !== 1'b0 || mm_stall !== 1'b0) begin errors++; $display("FAIL sc2_req: got wen %b stall %b required 0/0", dmemWEN, mm_stall); end
    nop_cycle();
    checks++; if (wb_wdat !== 32'h0 || wb_valid !== 1'b1) begin errors++; $display("FAIL sc2_wb: got %h/%b required 0/1", wb_wdat, wb_valid); end
    nop_cycle();
  endtask
`endif

  task automatic test_halt();
    int ren_seen = 0;
    @(negedge CLK); nop(); mm_valid = 1; mm_halt = 1;
    $display("halt");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); nop();
      mm_valid = 1; mm_dREN = 1; mm_RegWEN = 1; mm_MemtoReg = 2'd1; mm_rd = 7; mm_ALUOut = 32'h300; #1;
      ren_seen += int'(dmemREN);
      checks++; if (wb_halt !== 1'b1 || mm_stall !== 1'b0) begin errors++; $display("FAIL halt_state%0d: got halt %b stall %b required 1/0", i, wb_halt, mm_stall); end
    end
    $display("lw addr=0x300 after halt, ren cycles=%0d", ren_seen);
    checks++; if (ren_seen != 0) begin errors++; $display("FAIL halt_ren: got %0d required 0", ren_seen); end
    nop_cycle();
    checks++; if (wb_RegWEN !== 1'b0 || wb_wdat !== 32'h300 || wb_halt !== 1'b1) begin errors++; $display("FAIL halt_wb: got %b/%h/%b required 0/300/1", wb_RegWEN, wb_wdat, wb_halt); end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_lw();
    test_sw();
    test_jal_illegal();
    test_freeze();
`ifdef LLSC_EN
    test_llsc();
`endif
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
